// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the MD (multiply/divide) arbiter slice.
//   - MD_type bit indices: an MD operation is encoded one-hot, bit i set
//     selects operation i (MUL .. REMU).
//   - FSM state encoding used by md_arbiter.
//   - Default abort limit for the optional BUSY timeout
//     (feature enabled by the MD_ARB_TIMEOUT_EN macro in md_arbiter).
// ---------------------------------------------------------------------------
package md_pkg;

  localparam int MUL    = 0;
  localparam int MULH   = 1;
  localparam int MULHSU = 2;
  localparam int MULHU  = 3;
  localparam int DIV    = 4;
  localparam int DIVU   = 5;
  localparam int REM    = 6;
  localparam int REMU   = 7;

  localparam int MD_TYPE_W = REMU + 1;

  localparam int MD_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } md_state_e;

  // An operation is only meaningful to the MD unit when exactly one
  // MD_type bit is set; anything else is answered locally as an error.
  function automatic logic md_is_legal(input logic [MD_TYPE_W-1:0] op);
    return ($countones(op) == 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   req   [1:0]  request bits, bit i = requester i
//   ptr          last-served requester
//   grant [1:0]  one-hot winner, or zero when nobody requests
// A lone request always wins; when both request, the requester that was
// NOT served last wins, so neither side can starve the other.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Pick the winner; on a tie the pointer names the loser.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/md_arbiter.sv
// ---------------------------------------------------------------------------
// md_arbiter
// Shares one MD (multiply/divide) unit between two requesters. One request
// is accepted at a time, forwarded to the MD unit, and the result is held
// for the owning requester until it is consumed.
//
// Parameters:
//   TIMEOUT      max BUSY cycles before abort (only with MD_ARB_TIMEOUT_EN)
// Configuration macro:
//   MD_ARB_TIMEOUT_EN  when defined, a stuck MD unit (md_pending held high
//                      for TIMEOUT BUSY cycles) is aborted with an error
//                      response of all ones. When undefined, BUSY waits
//                      indefinitely.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid[1:0]              request strobes
//   req_op0/1, req_x0/1, req_y0/1  one-hot op and operands per requester
//   req_ready[1:0]              combinational grant (IDLE only)
//   rsp_valid[1:0], rsp_data, rsp_err, rsp_ready[1:0]  response handshake
//   md_type, md_x, md_y         command to the shared MD unit
//   md_out, md_pending          result / busy flag from the MD unit
// ---------------------------------------------------------------------------
module md_arbiter
  import md_pkg::*;
#(
  parameter int TIMEOUT = MD_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_op0,
  input  logic [7:0]  req_op1,
  input  logic [31:0] req_x0,
  input  logic [31:0] req_y0,
  input  logic [31:0] req_x1,
  input  logic [31:0] req_y1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic [1:0]  rsp_ready,
  output logic [7:0]  md_type,
  output logic [31:0] md_x,
  output logic [31:0] md_y,
  input  logic [31:0] md_out,
  input  logic        md_pending
);

  // A zero limit would abort before the MD unit ever sees the command.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("md_arbiter: TIMEOUT must be at least 1");
  end

  md_state_e   state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;

`ifdef MD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [1:0]  grant;
  logic        accept;
  logic [7:0]  sel_op;
  logic [31:0] sel_x;
  logic [31:0] sel_y;

  rr_arb2 u_rr_arb2 (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // The grant is only offered while idle, so requests arriving during
  // BUSY/RESP are simply ignored rather than queued.
  always_comb begin
    req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
    accept    = |(req_valid & req_ready);
    sel_op    = grant[1] ? req_op1 : req_op0;
    sel_x     = grant[1] ? req_x1  : req_x0;
    sel_y     = grant[1] ? req_y1  : req_y0;
  end

  // Next-state logic for the IDLE -> BUSY -> RESP -> IDLE cycle. Illegal
  // ops skip BUSY entirely and are answered with an error straight away.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef MD_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          op_d    = sel_op;
          x_d     = sel_x;
          y_d     = sel_y;
`ifdef MD_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (md_is_legal(sel_op)) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_RESP;
            res_d   = 32'd0;
            err_d   = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // A finished MD unit takes priority over the abort limit.
        if (!md_pending) begin
          state_d = ST_RESP;
          res_d   = md_out;
          err_d   = 1'b0;
        end
`ifdef MD_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          res_d   = 32'hFFFF_FFFF;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        // Only the owner's rsp_ready closes the transaction.
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any operation in flight and makes
  // requester 0 the winner of the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      op_q    <= 8'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      res_q   <= 32'd0;
      err_q   <= 1'b0;
`ifdef MD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef MD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs are decoded straight from registers and forced to zero outside
  // the state where they carry meaning.
  always_comb begin
    md_type   = (state_q == ST_BUSY) ? op_q : 8'd0;
    md_x      = (state_q == ST_BUSY) ? x_q  : 32'd0;
    md_y      = (state_q == ST_BUSY) ? y_q  : 32'd0;
    rsp_valid = 2'b00;
    rsp_data  = 32'd0;
    rsp_err   = 1'b0;
    if (state_q == ST_RESP) begin
      rsp_valid = owner_q ? 2'b10 : 2'b01;
      rsp_data  = res_q;
      rsp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_md_arbiter.sv
// ---------------------------------------------------------------------------
// tb_md_arbiter
// Self-checking bench for md_arbiter. A behavioural stand-in for the MD unit
// computes results with plain arithmetic and holds md_pending high for a
// programmable number of BUSY cycles. Expected grants, latencies and
// responses come from a small model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_md_arbiter;
  import md_pkg::*;

  localparam int TO = 64;
  localparam logic [7:0] OP_MUL = 8'(1 << MUL);
`ifdef MD_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [7:0]  req_op0, req_op1;
  logic [31:0] req_x0, req_y0, req_x1, req_y1;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  rsp_ready;
  logic [7:0]  md_type;
  logic [31:0] md_x, md_y, md_out;
  logic        md_pending;

  int   n_checks = 0;
  int   n_errors = 0;
  int   md_lat   = 0;
  int   busy_cnt = 0;
  logic ptr_m;

  always #5 clk = ~clk;

  md_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op0(req_op0), .req_op1(req_op1),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .md_type(md_type), .md_x(md_x), .md_y(md_y),
    .md_out(md_out), .md_pending(md_pending)
  );

  // Reference arithmetic for every MD_type.
  function automatic logic [31:0] md_ref(input logic [7:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    p  = 64'd0;
    if (op[MUL])         begin p = sx * sy; return p[31:0];  end
    else if (op[MULH])   begin p = sx * sy; return p[63:32]; end
    else if (op[MULHSU]) begin p = sx * uy; return p[63:32]; end
    else if (op[MULHU])  begin p = ux * uy; return p[63:32]; end
    else if (op[DIV])    begin if (y == 0) return 32'hFFFF_FFFF; p = sx / sy; return p[31:0]; end
    else if (op[DIVU])   begin if (y == 0) return 32'hFFFF_FFFF; p = ux / uy; return p[31:0]; end
    else if (op[REM])    begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
    else if (op[REMU])   begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
    return 32'd0;
  endfunction

  // MD unit stand-in: busy for md_lat cycles after a command appears.
  always @(posedge clk) begin
    if (md_type != 8'd0) busy_cnt <= busy_cnt + 1;
    else                 busy_cnt <= 0;
  end
  assign md_pending = (md_type != 8'd0) && (busy_cnt < md_lat);
  assign md_out     = md_ref(md_type, md_x, md_y);

  // Winner: lone requester, otherwise whoever was not served last.
  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
    int winner;
    if (v == 2'b00) return 2'b00;
    winner = (v == 2'b11) ? (1 - int'(last)) : (v[1] ? 1 : 0);
    return 2'(1 << winner);
  endfunction

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 8'(1 << r);
    return (r == 8) ? 8'h00 : 8'hA5;
  endfunction

  function automatic logic [31:0] rand_y();
    return ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1,
                                input logic [31:0] x0, input logic [31:0] y0,
                                input logic [31:0] x1, input logic [31:0] y1, input int lat);
    req_valid = v;
    req_op0 = o0; req_op1 = o1;
    req_x0 = x0; req_y0 = y0; req_x1 = x1; req_y1 = y1;
    md_lat = lat;
    rsp_ready = 2'b00;
  endtask

  // Called at a negedge; returns at the negedge just after the handshake.
  task automatic run_txn(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1,
                         input logic [31:0] x0, input logic [31:0] y0,
                         input logic [31:0] x1, input logic [31:0] y1,
                         input int lat, input int hold,
                         output logic got_owner, output logic [31:0] got_data, output logic got_err);
    logic [1:0]  exp_grant;
    logic        owner;
    logic [7:0]  op;
    logic [31:0] x, y, exp_data;
    logic        exp_err;
    int          exp_lat, cycles;
    bit          legal;
    apply_stimulus(v, o0, o1, x0, y0, x1, y1, lat);
    exp_grant = model_grant(v, ptr_m);
    #1;
    check_output("req_ready_grant", 32'(req_ready), 32'(exp_grant));
    owner = exp_grant[1];
    op = owner ? o1 : o0;
    x  = owner ? x1 : x0;
    y  = owner ? y1 : y0;
    legal = ($countones(op) == 1);
    if (!legal) begin
      exp_data = 32'd0; exp_err = 1'b1; exp_lat = 1;
    end else if (TIMEOUT_ON && lat >= TO) begin
      exp_data = 32'hFFFF_FFFF; exp_err = 1'b1; exp_lat = TO + 1;
    end else begin
      exp_data = md_ref(op, x, y); exp_err = 1'b0; exp_lat = lat + 2;
    end
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (rsp_valid == 2'b00) begin
        check_output("busy_md_type", 32'(md_type), legal ? 32'(op) : 32'd0);
        if (legal) begin
          check_output("busy_md_x", md_x, x);
          check_output("busy_md_y", md_y, y);
        end
        check_output("busy_req_ready", 32'(req_ready), 32'd0);
        check_output("busy_rsp_data_zero", rsp_data, 32'd0);
      end
    end while (rsp_valid == 2'b00 && cycles < 200);
    check_output("latency", 32'(cycles), 32'(exp_lat));
    check_output("rsp_valid", 32'(rsp_valid), owner ? 32'd2 : 32'd1);
    check_output("rsp_data", rsp_data, exp_data);
    check_output("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_output("resp_md_type", 32'(md_type), 32'd0);
    got_owner = rsp_valid[1];
    got_data  = rsp_data;
    got_err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = owner ? 2'b01 : 2'b10;
      @(negedge clk);
      check_output("hold_rsp_valid", 32'(rsp_valid), owner ? 32'd2 : 32'd1);
      check_output("hold_rsp_data", rsp_data, exp_data);
      check_output("hold_rsp_err", 32'(rsp_err), 32'(exp_err));
      check_output("hold_req_ready", 32'(req_ready), 32'd0);
      check_output("hold_md_type", 32'(md_type), 32'd0);
    end
    rsp_ready = owner ? 2'b10 : 2'b01;
    @(negedge clk);
    ptr_m = owner;
    rsp_ready = 2'b00;
    check_output("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("post_rsp_data", rsp_data, 32'd0);
    check_output("post_rsp_err", 32'(rsp_err), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(2'b00, 8'd0, 8'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    @(negedge clk);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_data", rsp_data, 32'd0);
    check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_output("rst_md_type", 32'(md_type), 32'd0);
    rst_n = 1'b1;
    ptr_m = 1'b1;
  endtask

  initial begin
    logic        g_owner, g_err;
    logic [31:0] g_data;
    logic [1:0]  v;
    int          stuck_cycles;
    logic [31:0] exp_seq [4];
    exp_seq = '{32'd15, 32'd16, 32'd15, 32'd16};

    rst_n = 1'b0;
    ptr_m = 1'b1;
    apply_stimulus(2'b00, 8'd0, 8'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    $display("[TB] reset");
    do_reset();

    $display("[TB] MUL 7*6 with 10-cycle response stall");
    run_txn(2'b01, OP_MUL, 8'd0, 32'd7, 32'd6, 32'd0, 32'd0, 2, 10, g_owner, g_data, g_err);
    check_output("mul_7x6_data", g_data, 32'd42);
    check_output("mul_7x6_owner", 32'(g_owner), 32'd0);

    $display("[TB] both requesters continuously");
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_txn(2'b11, OP_MUL, OP_MUL, 32'd3, 32'd5, 32'd4, 32'd4, 0, 0, g_owner, g_data, g_err);
      check_output("alt_owner", 32'(g_owner), 32'(k % 2));
      check_output("alt_data", g_data, exp_seq[k]);
    end

    $display("[TB] illegal op");
    run_txn(2'b01, 8'b0000_0011, 8'd0, 32'd1, 32'd2, 32'd0, 32'd0, 0, 1, g_owner, g_data, g_err);
    check_output("illegal_err", 32'(g_err), 32'd1);
    check_output("illegal_data", g_data, 32'd0);

`ifdef MD_ARB_TIMEOUT_EN
    $display("[TB] timeout abort");
    run_txn(2'b01, OP_MUL, 8'd0, 32'd3, 32'd3, 32'd0, 32'd0, 100000, 1, g_owner, g_data, g_err);
    check_output("timeout_data", g_data, 32'hFFFF_FFFF);
    check_output("timeout_err", 32'(g_err), 32'd1);
`endif

    $display("[TB] reset while BUSY");
    stuck_cycles = TIMEOUT_ON ? 20 : 100;
    apply_stimulus(2'b01, OP_MUL, 8'd0, 32'd5, 32'd5, 32'd0, 32'd0, 100000);
    @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < stuck_cycles; i++) begin
      check_output("stuck_md_type", 32'(md_type), 32'(OP_MUL));
      check_output("stuck_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 1'b1;
    md_lat = 0;
    for (int i = 0; i < 4; i++) begin
      check_output("abandon_md_type", 32'(md_type), 32'd0);
      check_output("abandon_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    run_txn(2'b10, 8'd0, OP_MUL, 32'd0, 32'd0, 32'd2, 32'd9, 1, 0, g_owner, g_data, g_err);
    check_output("after_rst_data", g_data, 32'd18);
    check_output("after_rst_owner", 32'(g_owner), 32'd1);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      v = 2'($urandom_range(1, 3));
      run_txn(v, rand_op(), rand_op(), 32'($urandom), rand_y(), 32'($urandom), rand_y(),
              $urandom_range(0, 4), $urandom_range(0, 3), g_owner, g_data, g_err);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        req_valid = 2'b00;
        #1;
        check_output("idle_req_ready", 32'(req_ready), 32'd0);
        check_output("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
